// File: rtl/qpp_addr_gen.sv
// qpp_addr_gen: recursive LTE QPP interleaver address generator for one lane.
// It tracks index i = offset + 8*n and presents pi(i) = (f1*i + f2*i^2) mod K.
// The recurrence uses modular adders only, with no multipliers.
// Optional feature: define QPP_SELFCHECK_EN to add a sticky err output.
// That output compares addr against a direct polynomial evaluation on every RUN cycle.
module qpp_addr_gen #(
  parameter int ADDR_W   = 13,
  parameter int OFFSET_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                block_size,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                step,
  output logic [ADDR_W-1:0]   addr,
  output logic                ready,
  output logic                done
`ifdef QPP_SELFCHECK_EN
  ,
  output logic                err
`endif
);

  localparam int SW     = ADDR_W + 1;
  localparam int STRIDE = 1 << OFFSET_W;

  // Per-block-size constants (small / large); all pre-reduced mod K.
  localparam logic [ADDR_W-1:0] K_S   = ADDR_W'(1056);
  localparam logic [ADDR_W-1:0] K_L   = ADDR_W'(6144);
  localparam logic [ADDR_W-1:0] H0_S  = ADDR_W'(83);
  localparam logic [ADDR_W-1:0] H0_L  = ADDR_W'(743);
  localparam logic [ADDR_W-1:0] DH_S  = ADDR_W'(132);
  localparam logic [ADDR_W-1:0] DH_L  = ADDR_W'(960);
  localparam logic [ADDR_W-1:0] G0_S  = ADDR_W'(136);
  localparam logic [ADDR_W-1:0] G0_L  = ADDR_W'(2104);
  localparam logic [ADDR_W-1:0] DG0_S = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] DG0_L = ADDR_W'(1536);
  localparam logic [ADDR_W-1:0] DG_S  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] DG_L  = ADDR_W'(0);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic                r_bsel;
  logic [ADDR_W-1:0]   r_pi;   // pi(idx)
  logic [ADDR_W-1:0]   r_h;    // unit-stride delta pi(idx+1)-pi(idx)
  logic [ADDR_W-1:0]   r_g;    // stride-8 delta pi(idx+8)-pi(idx)
  logic [ADDR_W-1:0]   r_idx;
  logic [OFFSET_W-1:0] r_cnt;
  logic                r_ready;
  logic                r_done;

  logic [ADDR_W-1:0]   w_k, w_dh, w_dg0, w_dg;
  logic [ADDR_W-1:0]   w_pi_h, w_h_dh, w_g_dg0, w_pi_g, w_g_dg;
  logic                w_last;

  // The two operands are both below K, so the sum is below 2K.
  // One conditional subtract therefore keeps the result inside [0, K-1].
  function automatic logic [ADDR_W-1:0] f_modadd(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] k);
    logic [SW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[ADDR_W-1:0];
  endfunction

  // Select the latched-size constants and form every candidate next value.
  always_comb begin
    w_k     = r_bsel ? K_L   : K_S;
    w_dh    = r_bsel ? DH_L  : DH_S;
    w_dg0   = r_bsel ? DG0_L : DG0_S;
    w_dg    = r_bsel ? DG_L  : DG_S;
    w_pi_h  = f_modadd(r_pi, r_h,   w_k);
    w_h_dh  = f_modadd(r_h,  w_dh,  w_k);
    w_g_dg0 = f_modadd(r_g,  w_dg0, w_k);
    w_pi_g  = f_modadd(r_pi, r_g,   w_k);
    w_g_dg  = f_modadd(r_g,  w_dg,  w_k);
    w_last  = ({1'b0, r_idx} + SW'(STRIDE)) >= {1'b0, w_k};
  end

  // Control FSM and accumulators.
  // Start overrides step; in INIT, the final iteration lands directly in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bsel  <= 1'b0;
      r_pi    <= '0;
      r_h     <= '0;
      r_g     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_bsel  <= block_size;
      r_pi    <= '0;
      r_h     <= block_size ? H0_L : H0_S;
      r_g     <= block_size ? G0_L : G0_S;
      r_idx   <= '0;
      r_cnt   <= offset;
      r_done  <= 1'b0;
      r_ready <= (offset == '0);
      r_state <= (offset == '0) ? S_RUN : S_INIT;
    end else begin
      case (r_state)
        S_INIT: begin
          r_pi  <= w_pi_h;
          r_h   <= w_h_dh;
          r_g   <= w_g_dg0;
          r_idx <= r_idx + ADDR_W'(1);
          r_cnt <= r_cnt - OFFSET_W'(1);
          if (r_cnt == OFFSET_W'(1)) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (step) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pi  <= w_pi_g;
              r_g   <= w_g_dg;
              r_idx <= r_idx + ADDR_W'(STRIDE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addr  = r_pi;
  assign ready = r_ready;
  assign done  = r_done;

`ifdef QPP_SELFCHECK_EN
  logic [31:0] w_idx32, w_sq, w_sq_m, w_ref_raw, w_ref;
  logic        r_err;

  // Direct polynomial evaluation of pi(idx).
  // The square is reduced first so that every product fits in 32 bits.
  always_comb begin
    w_idx32   = 32'(r_idx);
    w_sq      = w_idx32 * w_idx32;
    w_sq_m    = r_bsel ? (w_sq % 32'd6144) : (w_sq % 32'd1056);
    w_ref_raw = r_bsel ? (32'd263 * w_idx32 + 32'd480 * w_sq_m)
                       : (32'd17  * w_idx32 + 32'd66  * w_sq_m);
    w_ref     = r_bsel ? (w_ref_raw % 32'd6144) : (w_ref_raw % 32'd1056);
  end

  // Sticky mismatch flag; it is cleared only by reset or start.
  always_ff @(posedge clk) begin
    if (reset || start) r_err <= 1'b0;
    else if (r_state == S_RUN && w_ref != 32'(r_pi)) r_err <= 1'b1;
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_qpp_addr_gen.sv
// tb_qpp_addr_gen: randomized self-checking bench for qpp_addr_gen.
// Expected addresses come from the closed-form QPP polynomial (f1*i + f2*i^2) mod K.
module tb_qpp_addr_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       block_size = 1'b0;
  logic [2:0] offset = '0;
  logic       step = 1'b0;
  logic [12:0] addr;
  logic       ready;
  logic       done;
`ifdef QPP_SELFCHECK_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;

  qpp_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .block_size(block_size),
    .offset(offset), .step(step), .addr(addr), .ready(ready), .done(done)
`ifdef QPP_SELFCHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Closed-form reference for one block size.
  function automatic int qpp(input bit bs, input int i);
    longint k, f1, f2, ii;
    k  = bs ? 6144 : 1056;
    f1 = bs ? 263 : 17;
    f2 = bs ? 480 : 66;
    ii = i;
    return int'((f1 * ii + f2 * ii * ii) % k);
  endfunction

  function automatic int kof(input bit bs);
    return bs ? 6144 : 1056;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start.
  // Returns how many cycles pass, counting the start cycle itself, until ready is seen.
  task automatic do_start(input bit bs, input int off, input bit rnd_step, output int lat);
    block_size = bs;
    offset = 3'(off);
    start = 1'b1;
    if (rnd_step) step = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      if (rnd_step) step = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    step = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    total++;
    if (addr !== 13'd0 || ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: addr=%0d ready=%0b done=%0b, required 0/0/0", addr, ready, done);
    end
    do_start(1'b1, 0, 1'b0, lat);
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if (addr !== 13'd0 || ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: addr=%0d ready=%0b done=%0b, required 0/0/0", addr, ready, done);
    end
    reset = 1'b0;
    step = 1'b1;
    repeat (2) tick();
    step = 1'b0;
    total++;
    if (addr !== 13'd0 || ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_step: addr=%0d ready=%0b, required 0/0", addr, ready);
    end
    // Reset and start together: reset must win.
    reset = 1'b1;
    start = 1'b1;
    block_size = 1'b1;
    offset = 3'd0;
    tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    total++;
    if (ready !== 1'b0 || addr !== 13'd0) begin
      bad++;
      $display("FAIL reset_vs_start: ready=%0b addr=%0d, required 0/0", ready, addr);
    end
  endtask

  task automatic test_small_off0();
    int lat, i, n;
    do_start(1'b0, 0, 1'b0, lat);
    total++;
    if (lat != 1 || addr !== 13'd0) begin
      bad++;
      $display("FAIL small0_start: latency=%0d addr=%0d, required 1/0", lat, addr);
    end
    i = 0;
    n = 0;
    while (n < 200) begin
      step = 1'b1;
      tick();
      n++;
      if (i + 8 >= 1056) break;
      i += 8;
      total++;
      if (addr !== 13'((136 * n) % 1056) || ready !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL small0_seq n=%0d: addr=%0d ready=%0b, required %0d/1", n, addr, ready, (136 * n) % 1056);
      end
    end
    step = 1'b0;
    total++;
    if (n != 132 || done !== 1'b1 || ready !== 1'b0 || addr !== 13'(qpp(1'b0, 1048))) begin
      bad++;
      $display("FAIL small0_done: steps=%0d done=%0b addr=%0d, required 132/1/%0d", n, done, addr, qpp(1'b0, 1048));
    end
  endtask

  task automatic test_small_off3();
    int lat;
    do_start(1'b0, 3, 1'b0, lat);
    total++;
    if (lat != 4 || addr !== 13'd645) begin
      bad++;
      $display("FAIL small3_init: latency=%0d addr=%0d, required 4/645", lat, addr);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    total++;
    if (addr !== 13'd781) begin
      bad++;
      $display("FAIL small3_step: addr=%0d, required 781", addr);
    end
  endtask

  task automatic test_large_off1();
    int lat;
    int exp_a[3];
    exp_a = '{4383, 1879, qpp(1'b1, 25)};
    do_start(1'b1, 1, 1'b0, lat);
    total++;
    if (lat != 2 || addr !== 13'd743) begin
      bad++;
      $display("FAIL large1_init: latency=%0d addr=%0d, required 2/743", lat, addr);
    end
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      total++;
      if (addr !== 13'(exp_a[s])) begin
        bad++;
        $display("FAIL large1_step%0d: addr=%0d, required %0d", s, addr, exp_a[s]);
      end
    end
  endtask

  task automatic test_random_large();
    int lat, i, presented, cyc;
    bit s, m_done;
    do_start(1'b1, 7, 1'b1, lat);
    total++;
    if (lat != 8 || addr !== 13'(qpp(1'b1, 7))) begin
      bad++;
      $display("FAIL rand_init: latency=%0d addr=%0d, required 8/%0d", lat, addr, qpp(1'b1, 7));
    end
    i = 7;
    presented = 1;
    m_done = 1'b0;
    cyc = 0;
    while (!m_done && cyc < 5000) begin
      s = ($urandom_range(0, 2) != 0);
      step = s;
      tick();
      cyc++;
      if (s) begin
        if (i + 8 >= 6144) m_done = 1'b1;
        else begin
          i += 8;
          presented++;
        end
      end
      total++;
      if (addr !== 13'(qpp(1'b1, i)) || ready !== !m_done || done !== m_done) begin
        bad++;
        $display("FAIL rand_seq i=%0d: addr=%0d ready=%0b done=%0b, required %0d/%0b/%0b", i, addr, ready, done, qpp(1'b1, i), !m_done, m_done);
      end
    end
    total++;
    if (!m_done || presented != 768 || i != 6143) begin
      bad++;
      $display("FAIL rand_count: presented=%0d last=%0d, required 768/6143", presented, i);
    end
    step = 1'b1;
    repeat (4) tick();
    step = 1'b0;
    total++;
    if (addr !== 13'(qpp(1'b1, 6143)) || done !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL rand_done_hold: addr=%0d done=%0b, required %0d/1", addr, done, qpp(1'b1, 6143));
    end
  endtask

  task automatic test_restart();
    int lat, i;
    bit bs;
    do_start(1'b0, 5, 1'b0, lat);
    step = 1'b1;
    repeat (5) tick();
    // start together with step: the step must be dropped.
    block_size = 1'b1;
    offset = 3'd2;
    start = 1'b1;
    step = 1'b1;
    tick();
    start = 1'b0;
    step = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 3 || addr !== 13'(qpp(1'b1, 2))) begin
      bad++;
      $display("FAIL restart_run: latency=%0d addr=%0d, required 3/%0d", lat, addr, qpp(1'b1, 2));
    end
    // Abort mid-INIT with a random size and offset, then walk a few steps.
    block_size = 1'b0;
    offset = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bs = 1'($urandom_range(0, 1));
    i = $urandom_range(1, 7);
    do_start(bs, i, 1'b0, lat);
    total++;
    if (lat != i + 1 || addr !== 13'(qpp(bs, i))) begin
      bad++;
      $display("FAIL restart_init: latency=%0d addr=%0d, required %0d/%0d", lat, addr, i + 1, qpp(bs, i));
    end
    for (int s = 0; s < 6; s++) begin
      step = 1'b1;
      tick();
      i += 8;
      total++;
      if (addr !== 13'(qpp(bs, i)) || i >= kof(bs)) begin
        bad++;
        $display("FAIL restart_step%0d: addr=%0d, required %0d", s, addr, qpp(bs, i));
      end
    end
    step = 1'b0;
`ifdef QPP_SELFCHECK_EN
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL selfcheck_err: err=%0b, required 0", err);
    end
`endif
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_small_off0();
    test_small_off3();
    test_large_off1();
    test_random_large();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
